// File: rtl/standoff_pkg.sv
// Shared definitions for the Standoff round engine.
//   act_e   : per-player action codes as carried on act_code
//   state_e : round FSM encoding, also driven out on the state port
//   COUNT_W : width of the countdown value shown on the display
package standoff_pkg;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'b00,
        ACT_SHOOT  = 2'b01,
        ACT_RELOAD = 2'b10,
        ACT_DUCK   = 2'b11
    } act_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RESOLVE   = 3'd2,
        S_RESULT    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_e;

    localparam int COUNT_W = 7;

endpackage

// File: rtl/standoff_round_engine_if.sv
// Control and status bundle between the button logic, the round engine and
// the display drivers.
//   master : drives load, pause, act_valid, act_code; observes all status
//   slave  : the round engine side
//   load/pause            game start and freeze controls
//   act_valid/act_code    per-player action strobe, player i code at [2i+:2]
//   bullets/lives         per-player counters, player i at [i*BW+:BW]/[i*LW+:LW]
//   countdown/state       countdown value and FSM encoding
//   round_done/winner_vld/draw/winner_id   round and game outcome
interface standoff_round_engine_if
    import standoff_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_BULLETS = 6,
    parameter int LIVES       = 3
);
    localparam int BW = $clog2(MAX_BULLETS + 1);
    localparam int LW = $clog2(LIVES + 1);
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

    logic                       load;
    logic                       pause;
    logic [NUM_PLAYERS-1:0]     act_valid;
    logic [2*NUM_PLAYERS-1:0]   act_code;
    logic [NUM_PLAYERS*BW-1:0]  bullets;
    logic [NUM_PLAYERS*LW-1:0]  lives;
    logic [COUNT_W-1:0]         countdown;
    logic [2:0]                 state;
    logic                       round_done;
    logic                       winner_vld;
    logic                       draw;
    logic [PW-1:0]              winner_id;

    modport master (
        output load, pause, act_valid, act_code,
        input  bullets, lives, countdown, state, round_done, winner_vld, draw, winner_id
    );

    modport slave (
        input  load, pause, act_valid, act_code,
        output bullets, lives, countdown, state, round_done, winner_vld, draw, winner_id
    );

endinterface

// File: rtl/standoff_tick_counter.sv
// Countdown timebase: a prescaler dividing clk into ticks and the countdown
// value it decrements.
//   clk, reset     clock and synchronous active-high reset
//   enable_i       high while the round is counting down
//   pause_i        freezes prescaler and countdown
//   restart_i      reload countdown with COUNT_START and clear the prescaler
//   countdown_o    current countdown value
//   last_tick_o    the wrap that ends the final tick (countdown == 1)
module standoff_tick_counter
    import standoff_pkg::*;
#(
    parameter int COUNT_START  = 3,
    parameter int COUNT_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               pause_i,
    input  logic               restart_i,
    output logic [COUNT_W-1:0] countdown_o,
    output logic               last_tick_o
);
    localparam int PSW = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;

    logic [PSW-1:0]     presc_q;
    logic [COUNT_W-1:0] count_q;
    logic               run;
    logic               wrap;

    assign run         = enable_i && !pause_i;
    assign wrap        = run && (presc_q == PSW'(COUNT_CYCLES - 1));
    assign last_tick_o = wrap && (count_q == COUNT_W'(1));
    assign countdown_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (restart_i) begin
            presc_q <= '0;
            count_q <= COUNT_W'(COUNT_START);
        end else if (run) begin
            presc_q <= wrap ? '0 : presc_q + PSW'(1);
            // The final wrap leaves the value at 1; the FSM moves on instead.
            if (wrap && count_q != COUNT_W'(1)) begin
                count_q <= count_q - COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/standoff_round_engine.sv
// Standoff round engine for NUM_PLAYERS players: countdown, action capture,
// parallel resolve, result and game-over detection.
//   clk, reset  clock and synchronous active-high reset
//   bus         standoff_round_engine_if.slave: controls in, status out
module standoff_round_engine
    import standoff_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int MAX_BULLETS   = 6,
    parameter int START_BULLETS = 1,
    parameter int LIVES         = 3,
    parameter int COUNT_START   = 3,
    parameter int COUNT_CYCLES  = 100_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    standoff_round_engine_if.slave bus
);
    localparam int BW = $clog2(MAX_BULLETS + 1);
    localparam int LW = $clog2(LIVES + 1);
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW = $clog2(NUM_PLAYERS + 1);

    state_e                    state_q, state_d;
    logic                      start_game;
    logic                      restart;
    logic                      last_tick;
    logic                      capture_en;
    logic                      show_result;
    logic [COUNT_W-1:0]        countdown;
    logic [NUM_PLAYERS-1:0]    alive, shoot_ok, is_duck, has_tgt;
    logic [2*NUM_PLAYERS-1:0]  alive2;
    logic [NUM_PLAYERS*PW-1:0] tgt_flat;
    logic [CW-1:0]             alive_cnt;
    logic [PW-1:0]             last_alive;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_game = 1'b0;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (bus.load) begin
                    state_d    = S_COUNTDOWN;
                    start_game = 1'b1;
                end
            end
            S_COUNTDOWN: if (last_tick) state_d = S_RESOLVE;
            S_RESOLVE:   state_d = S_RESULT;
            S_RESULT:    state_d = (alive_cnt <= CW'(1)) ? S_GAME_OVER : S_COUNTDOWN;
            default:     state_d = S_IDLE;
        endcase
    end

    // Every entry into COUNTDOWN (new game or next round) restarts the timebase
    // and empties the action latches.
    assign restart    = (state_d == S_COUNTDOWN) && (state_q != S_COUNTDOWN);
    assign capture_en = (state_q == S_COUNTDOWN) && !bus.pause;

    standoff_tick_counter #(
        .COUNT_START  (COUNT_START),
        .COUNT_CYCLES (COUNT_CYCLES)
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (state_q == S_COUNTDOWN),
        .pause_i     (bus.pause),
        .restart_i   (restart),
        .countdown_o (countdown),
        .last_tick_o (last_tick)
    );

    // ---------------- survivors ----------------
    always_comb begin
        alive_cnt  = '0;
        last_alive = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (alive[p]) begin
                alive_cnt  = alive_cnt + CW'(1);
                last_alive = PW'(p);
            end
        end
    end

    // Doubled copy so each player can view the others in wrap-around order.
    assign alive2 = {alive, alive};

    // ---------------- per-player datapath ----------------
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [BW-1:0]          bullets_q, bullets_d;
        logic [LW-1:0]          lives_q, lives_d;
        logic [1:0]             act_q;
        logic [NUM_PLAYERS-1:0] alive_rot;
        logic [PW-1:0]          tgt;
        logic                   tgt_found;
        logic [CW-1:0]          hits;

        assign alive_rot                = alive2[gi +: NUM_PLAYERS];
        assign alive[gi]                = (lives_q != '0);
        assign shoot_ok[gi]             = (act_q == ACT_SHOOT) && (bullets_q != '0);
        assign is_duck[gi]              = (act_q == ACT_DUCK);
        assign has_tgt[gi]              = tgt_found;
        assign tgt_flat[gi*PW +: PW]    = tgt;
        assign bus.bullets[gi*BW +: BW] = bullets_q;
        assign bus.lives[gi*LW +: LW]   = lives_q;

        // Nearest alive player after gi; scanned from the far end so the
        // nearest one is written last.
        always_comb begin
            tgt       = '0;
            tgt_found = 1'b0;
            for (int k = NUM_PLAYERS - 1; k >= 1; k--) begin
                if (alive_rot[k]) begin
                    tgt       = PW'((gi + k) % NUM_PLAYERS);
                    tgt_found = 1'b1;
                end
            end
        end

        always_comb begin
            hits = '0;
            for (int s = 0; s < NUM_PLAYERS; s++) begin
                if (shoot_ok[s] && has_tgt[s] && !is_duck[gi] &&
                    tgt_flat[s*PW +: PW] == PW'(gi)) begin
                    hits = hits + CW'(1);
                end
            end
        end

        always_comb begin
            bullets_d = bullets_q;
            lives_d   = lives_q;
            if (shoot_ok[gi]) begin
                bullets_d = bullets_q - BW'(1);
            end else if (act_q == ACT_RELOAD && bullets_q < BW'(MAX_BULLETS)) begin
                bullets_d = bullets_q + BW'(1);
            end
            if (int'(hits) >= int'(lives_q)) lives_d = '0;
            else                             lives_d = lives_q - LW'(hits);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                bullets_q <= BW'(START_BULLETS);
                lives_q   <= LW'(LIVES);
                act_q     <= ACT_NONE;
            end else begin
                if (start_game) begin
                    bullets_q <= BW'(START_BULLETS);
                    lives_q   <= LW'(LIVES);
                end else if (state_q == S_RESOLVE) begin
                    bullets_q <= bullets_d;
                    lives_q   <= lives_d;
                end
                // First action of the round sticks; eliminated players stay idle.
                if (restart) begin
                    act_q <= ACT_NONE;
                end else if (capture_en && bus.act_valid[gi] &&
                             act_q == ACT_NONE && lives_q != '0) begin
                    act_q <= bus.act_code[2*gi +: 2];
                end
            end
        end
    end

    // ---------------- status ----------------
    assign show_result    = (state_q == S_RESULT) || (state_q == S_GAME_OVER);
    assign bus.state      = state_q;
    assign bus.countdown  = countdown;
    assign bus.round_done = (state_q == S_RESULT);
    assign bus.winner_vld = (state_q == S_GAME_OVER);
    assign bus.draw       = show_result && (alive_cnt == '0);
    assign bus.winner_id  = (show_result && alive_cnt == CW'(1)) ? last_alive : '0;

endmodule

// File: tb/tb_standoff_round_engine.sv
// Self-checking bench for standoff_round_engine (2 players, 3 bullets max,
// 2 lives, countdown 3 ticks of 4 cycles). A cycle-level game model tracks
// the expected round phase, remaining countdown cycles, per-player counters
// and latched actions; every cycle all outputs are compared against it.
module tb_standoff_round_engine;
    import standoff_pkg::*;

    localparam int N  = 2;
    localparam int MB = 3;
    localparam int SB = 1;
    localparam int LV = 2;
    localparam int CS = 3;
    localparam int CC = 4;
    localparam int BW = $clog2(MB + 1);
    localparam int LW = $clog2(LV + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    standoff_round_engine_if #(.NUM_PLAYERS(N), .MAX_BULLETS(MB), .LIVES(LV)) bus ();

    standoff_round_engine #(
        .NUM_PLAYERS   (N),
        .MAX_BULLETS   (MB),
        .START_BULLETS (SB),
        .LIVES         (LV),
        .COUNT_START   (CS),
        .COUNT_CYCLES  (CC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    state_e m_state;
    int     m_left;
    int     m_bul [N];
    int     m_liv [N];
    int     m_act [N];   // 0 none, 1 shoot, 2 reload, 3 duck

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bul(input int i);
        return int'(bus.bullets[i*BW +: BW]);
    endfunction

    function automatic int liv(input int i);
        return int'(bus.lives[i*LW +: LW]);
    endfunction

    function automatic int m_alive_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_liv[i] > 0) c++;
        return c;
    endfunction

    task automatic m_new_game();
        for (int i = 0; i < N; i++) begin
            m_bul[i] = SB;
            m_liv[i] = LV;
            m_act[i] = 0;
        end
    endtask

    task automatic m_enter_countdown();
        m_state = S_COUNTDOWN;
        m_left  = CS * CC;
        for (int i = 0; i < N; i++) m_act[i] = 0;
    endtask

    task automatic m_resolve();
        int dmg [N];
        int nb  [N];
        for (int i = 0; i < N; i++) begin
            dmg[i] = 0;
            nb[i]  = m_bul[i];
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i] == 1 && m_bul[i] > 0) begin
                nb[i] = m_bul[i] - 1;
                for (int k = 1; k < N; k++) begin
                    int j;
                    j = (i + k) % N;
                    if (m_liv[j] > 0) begin
                        if (m_act[j] != 3) dmg[j]++;
                        break;
                    end
                end
            end else if (m_act[i] == 2) begin
                nb[i] = (m_bul[i] < MB) ? m_bul[i] + 1 : MB;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_bul[i] = nb[i];
            m_liv[i] = (dmg[i] >= m_liv[i]) ? 0 : m_liv[i] - dmg[i];
        end
    endtask

    task automatic model_step(input logic rs, input logic ld, input logic ps,
                              input logic [N-1:0] v, input logic [2*N-1:0] c);
        if (rs) begin
            m_state = S_IDLE;
            m_left  = 0;
            m_new_game();
        end else begin
            case (m_state)
                S_IDLE, S_GAME_OVER: begin
                    if (ld) begin
                        m_new_game();
                        m_enter_countdown();
                    end
                end
                S_COUNTDOWN: begin
                    if (!ps) begin
                        for (int i = 0; i < N; i++)
                            if (v[i] && m_act[i] == 0 && m_liv[i] > 0)
                                m_act[i] = int'(c[2*i +: 2]);
                        m_left--;
                        if (m_left == 0) m_state = S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    m_resolve();
                    m_state = S_RESULT;
                end
                S_RESULT: begin
                    if (m_alive_cnt() <= 1) m_state = S_GAME_OVER;
                    else                    m_enter_countdown();
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        bit shown;
        int win;
        shown = (m_state == S_RESULT) || (m_state == S_GAME_OVER);
        win = 0;
        for (int i = 0; i < N; i++) if (m_liv[i] > 0) win = i;
        chk("state", int'(bus.state), int'(m_state));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bullets%0d", i), bul(i), m_bul[i]);
            chk($sformatf("lives%0d", i), liv(i), m_liv[i]);
        end
        if (m_state == S_COUNTDOWN) chk("countdown", int'(bus.countdown), (m_left + CC - 1) / CC);
        if (m_state == S_IDLE)      chk("countdown_idle", int'(bus.countdown), 0);
        chk("round_done", int'(bus.round_done), (m_state == S_RESULT) ? 1 : 0);
        chk("winner_vld", int'(bus.winner_vld), (m_state == S_GAME_OVER) ? 1 : 0);
        chk("draw", int'(bus.draw), (shown && m_alive_cnt() == 0) ? 1 : 0);
        chk("winner_id", int'(bus.winner_id), (shown && m_alive_cnt() == 1) ? win : 0);
    endtask

    // One clock: drive inputs, advance model at the edge, check on the falling edge.
    task automatic tick(input logic rs, input logic ld, input logic ps,
                        input logic [N-1:0] v, input logic [2*N-1:0] c);
        reset         = rs;
        bus.load      = ld;
        bus.pause     = ps;
        bus.act_valid = v;
        bus.act_code  = c;
        @(posedge clk);
        model_step(rs, ld, ps, v, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
    endtask

    // Strobe both players on the first countdown cycle, optionally strobe
    // again two cycles later, then run through RESULT.
    task automatic play_round(input logic [3:0] c, input logic [1:0] lv, input logic [3:0] lc);
        tick(1'b0, 1'b0, 1'b0, 2'b11, c);
        idle();
        tick(1'b0, 1'b0, 1'b0, lv, lc);
        for (int n = 0; n < 100 && bus.state != S_RESULT; n++) idle();
        chk("reach_result", int'(bus.state), int'(S_RESULT));
        $display("round acts=%b -> bullets %0d/%0d lives %0d/%0d draw=%0d winner_id=%0d",
                 c, bul(0), bul(1), liv(0), liv(1), bus.draw, bus.winner_id);
        idle();
    endtask

    logic       r_rs, r_ld, r_ps;
    logic [1:0] r_v;
    logic [3:0] r_c;
    int         lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, including reset winning over load and pause.
        tick(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
        tick(1'b1, 1'b1, 1'b1, 2'b11, 4'b1111);
        chk("rst_state", int'(bus.state), int'(S_IDLE));
        chk("rst_lives1", liv(1), LV);
        idle();

        // Countdown timing and RESOLVE latency.
        tick(1'b0, 1'b1, 1'b0, 2'b00, 4'b0000);
        chk("cd_start", int'(bus.countdown), CS);
        lat = 0;
        for (int n = 0; n < 40 && bus.state != S_RESOLVE; n++) begin
            idle();
            lat++;
        end
        chk("resolve_latency", lat, CS * CC);
        idle();
        chk("round_done_pulse", int'(bus.round_done), 1);
        idle();
        chk("next_round_cd", int'(bus.countdown), CS);

        // P0 shoot, P1 duck.
        play_round(4'b1101, 2'b00, 4'b0000);
        chk("duck_b0", bul(0), 0);
        chk("duck_l1", liv(1), 2);
        chk("duck_next_cd", int'(bus.countdown), CS);
        // P0 reload.
        play_round(4'b0010, 2'b00, 4'b0000);
        chk("reload_b0", bul(0), 1);
        // P0 shoot, P1 reload.
        play_round(4'b1001, 2'b00, 4'b0000);
        chk("hit_l1", liv(1), 1);
        chk("hit_b1", bul(1), 2);
        chk("hit_b0", bul(0), 0);
        // P0 dry fire, P1 reload to max, then saturate.
        play_round(4'b1001, 2'b00, 4'b0000);
        chk("dry_l1", liv(1), 1);
        chk("reload_b1", bul(1), 3);
        play_round(4'b1001, 2'b00, 4'b0000);
        chk("sat_b1", bul(1), 3);
        // P1 reloads, later shoot strobe in the same round must not count.
        play_round(4'b1010, 2'b10, 4'b0100);
        chk("second_strobe_l0", liv(0), 2);
        chk("second_strobe_b1", bul(1), 3);
        // Bring both to one life, then mutual kill.
        play_round(4'b0110, 2'b00, 4'b0000);
        chk("setup_l0", liv(0), 1);
        play_round(4'b0101, 2'b00, 4'b0000);
        chk("go_state", int'(bus.state), int'(S_GAME_OVER));
        chk("go_winner_vld", int'(bus.winner_vld), 1);
        chk("go_draw", int'(bus.draw), 1);
        chk("go_winner_id", int'(bus.winner_id), 0);
        tick(1'b0, 1'b0, 1'b0, 2'b11, 4'b0101);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 4'b0000);
        chk("reload_game_l0", liv(0), LV);
        chk("reload_game_b1", bul(1), SB);

        // Pause mid-countdown.
        tick(1'b0, 1'b0, 1'b0, 2'b01, 4'b0001);
        repeat (3) idle();
        for (int n = 0; n < 10; n++) tick(1'b0, 1'b0, 1'b1, 2'b10, 4'b0100);
        chk("pause_cd", int'(bus.countdown), 2);
        lat = 14;
        for (int n = 0; n < 40 && bus.state != S_RESOLVE; n++) begin
            idle();
            lat++;
        end
        chk("pause_latency", lat, CS * CC + 10);
        idle();
        chk("pause_l1", liv(1), 1);
        chk("pause_l0", liv(0), 2);
        idle();

        // Reset mid-countdown.
        tick(1'b0, 1'b0, 1'b0, 2'b01, 4'b0001);
        tick(1'b1, 1'b0, 1'b0, 2'b11, 4'b0101);
        chk("midrst_state", int'(bus.state), int'(S_IDLE));
        chk("midrst_l1", liv(1), LV);
        tick(1'b0, 1'b0, 1'b0, 2'b11, 4'b0101);
        tick(1'b0, 1'b1, 1'b0, 2'b00, 4'b0000);
        play_round(4'b0000, 2'b00, 4'b0000);
        chk("midrst_round_l1", liv(1), LV);

        // Randomized play.
        for (int n = 0; n < 4000; n++) begin
            r_rs   = ($urandom_range(0, 799) == 0);
            r_ld   = ($urandom_range(0, 3) == 0);
            r_ps   = ($urandom_range(0, 7) == 0);
            r_v[0] = ($urandom_range(0, 5) == 0);
            r_v[1] = ($urandom_range(0, 5) == 0);
            r_c    = 4'($urandom);
            tick(r_rs, r_ld, r_ps, r_v, r_c);
            if (bus.round_done)
                $display("random round -> bullets %0d/%0d lives %0d/%0d draw=%0d winner_id=%0d",
                         bul(0), bul(1), liv(0), liv(1), bus.draw, bus.winner_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
